// File: rtl/bfly_ctrl_if.sv
// Handshake and control bundle between the butterfly stage controller
// and the surrounding datapath.
interface bfly_ctrl_if #(
    parameter int CNT_W = 4
);
    logic             din_valid;
    logic             din_ready;
    logic             flush;
    logic             bfly_valid;
    logic             sr_wr_sel;
    logic             dout_sel;
    logic             dout_valid;
    logic             tw_valid;
    logic [CNT_W-1:0] tw_idx;
    logic             frame_done;
    logic             busy;

    modport slave (
        input  din_valid,
        input  flush,
        output din_ready,
        output bfly_valid,
        output sr_wr_sel,
        output dout_sel,
        output dout_valid,
        output tw_valid,
        output tw_idx,
        output frame_done,
        output busy
    );

    modport master (
        output din_valid,
        output flush,
        input  din_ready,
        input  bfly_valid,
        input  sr_wr_sel,
        input  dout_sel,
        input  dout_valid,
        input  tw_valid,
        input  tw_idx,
        input  frame_done,
        input  busy
    );
endinterface

// File: rtl/bfly_ctrl.sv
// Sequencer for one radix-2 SDF butterfly stage: fills the delay line,
// runs the butterflies, then emits the held differences.
module bfly_ctrl #(
    parameter int NUM_PAIR = 16,
    parameter int CNT_W    = $clog2(NUM_PAIR)
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         en,
    bfly_ctrl_if.slave   bus
);
    typedef enum logic [1:0] {
        FILL  = 2'd0,
        BFLY  = 2'd1,
        DRAIN = 2'd2
    } state_e;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(NUM_PAIR - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pend_q, pend_d;
    logic             fd_q, fd_d;

    logic st_fill, st_bfly, st_drain;
    logic last, accept, rdy, dov, dsel, twv;

    assign st_fill  = (state_q == FILL);
    assign st_bfly  = (state_q == BFLY);
    assign st_drain = (state_q == DRAIN);
    assign last     = (cnt_q == LAST);
    assign rdy      = en & ~st_drain;
    assign accept   = en & bus.din_valid & rdy;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= FILL;
            cnt_q   <= '0;
            pend_q  <= 1'b0;
            fd_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            fd_q    <= fd_d;
        end
    end

    // cnt wraps naturally at LAST since NUM_PAIR is a power of two
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pend_d  = pend_q;
        case (state_q)
            FILL: begin
                if (accept) begin
                    cnt_d = cnt_q + 1'b1;
                    if (last) begin
                        state_d = BFLY;
                        pend_d  = 1'b0;
                    end
                end else if (en & bus.flush & pend_q &
                             (cnt_q == '0) & ~bus.din_valid) begin
                    state_d = DRAIN;
                end
            end
            BFLY: begin
                if (accept) begin
                    cnt_d = cnt_q + 1'b1;
                    if (last) begin
                        state_d = FILL;
                        pend_d  = 1'b1;
                    end
                end
            end
            DRAIN: begin
                if (en) begin
                    cnt_d = cnt_q + 1'b1;
                    if (last) begin
                        state_d = FILL;
                        pend_d  = 1'b0;
                    end
                end
            end
            default: begin
                state_d = FILL;
                cnt_d   = '0;
                pend_d  = 1'b0;
            end
        endcase
    end

    always_comb begin
        dsel = ~st_bfly;
        dov  = (accept & (st_bfly | (st_fill & pend_q)))
             | (en & st_drain);
        twv  = dov & dsel;
        fd_d = twv & last;
    end

    assign bus.din_ready  = rdy;
    assign bus.bfly_valid = accept & st_bfly;
    assign bus.sr_wr_sel  = st_bfly;
    assign bus.dout_sel   = dsel;
    assign bus.dout_valid = dov;
    assign bus.tw_valid   = twv;
    assign bus.tw_idx     = twv ? cnt_q : '0;
    assign bus.frame_done = fd_q;
    assign bus.busy       = ~st_fill | (cnt_q != '0) | pend_q;
endmodule

// File: tb/tb_bfly_ctrl.sv
// Phase-table bench for bfly_ctrl with NUM_PAIR=16.
module tb_bfly_ctrl;
    localparam int NP = 16;
    localparam int CW = 4;

    logic clk = 1'b0;
    logic rstn;
    logic en;

    bfly_ctrl_if #(.CNT_W(CW)) bus ();

    bfly_ctrl #(.NUM_PAIR(NP), .CNT_W(CW)) dut (
        .clk  (clk),
        .rstn (rstn),
        .en   (en),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        int n;
        bit rstn, en, dv, fl, chk;
        bit rdy, bv, dov, dsel, wsel, tw;
        int idx0;
        bit fd_end, busy_end;
    } vec_t;

    typedef struct {
        bit       chk;
        bit       rdy, bv, dov, dsel, wsel, tw;
        bit [3:0] idx;
        bit       fd;
    } exp_t;

    exp_t sb[$];
    vec_t tbl[$];
    int   checks = 0;
    int   failures = 0;
    int   ph = 0;

    function automatic vec_t mk(int n, bit r, bit e, bit dv, bit fl, bit c,
                                bit rdy, bit bv, bit dov, bit dsel,
                                bit wsel, bit tw, int idx0, bit fd, bit bz);
        vec_t v;
        v.n = n; v.rstn = r; v.en = e; v.dv = dv; v.fl = fl; v.chk = c;
        v.rdy = rdy; v.bv = bv; v.dov = dov; v.dsel = dsel;
        v.wsel = wsel; v.tw = tw; v.idx0 = idx0;
        v.fd_end = fd; v.busy_end = bz;
        return v;
    endfunction

    task automatic cmp(string nm, int act, int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL ph%0d %s actual=%0d required=%0d",
                     ph, nm, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v);
        exp_t e;
        for (int i = 0; i < v.n; i++) begin
            @(negedge clk);
            rstn          = v.rstn;
            en            = v.en;
            bus.din_valid = v.dv;
            bus.flush     = v.fl;
            e.chk  = v.chk;
            e.rdy  = v.rdy;  e.bv   = v.bv;   e.dov = v.dov;
            e.dsel = v.dsel; e.wsel = v.wsel; e.tw  = v.tw;
            e.idx  = v.tw ? 4'(v.idx0 + i) : 4'd0;
            e.fd   = (i == v.n - 1) ? v.fd_end : 1'b0;
            sb.push_back(e);
            #1;
            e = sb.pop_front();
            if (e.chk) begin
                cmp("din_ready",  int'(bus.din_ready),  int'(e.rdy));
                cmp("bfly_valid", int'(bus.bfly_valid), int'(e.bv));
                cmp("dout_valid", int'(bus.dout_valid), int'(e.dov));
                cmp("dout_sel",   int'(bus.dout_sel),   int'(e.dsel));
                cmp("sr_wr_sel",  int'(bus.sr_wr_sel),  int'(e.wsel));
                cmp("tw_valid",   int'(bus.tw_valid),   int'(e.tw));
                cmp("tw_idx",     int'(bus.tw_idx),     int'(e.idx));
            end
            @(posedge clk);
            #1;
            cmp("frame_done", int'(bus.frame_done), int'(e.fd));
            if (i == v.n - 1)
                cmp("busy", int'(bus.busy), int'(v.busy_end));
        end
        ph++;
    endtask

    initial begin
        rstn = 1'b0;
        en = 1'b1;
        bus.din_valid = 1'b0;
        bus.flush = 1'b0;

        //            n  r e v f c  rdy bv dov ds ws tw idx fd bz
        tbl.push_back(mk(2,  0,1,0,0,0, 0,0,0,0,0,0, 0, 0,0));
        tbl.push_back(mk(1,  1,1,0,0,1, 1,0,0,1,0,0, 0, 0,0));
        tbl.push_back(mk(1,  1,0,0,0,1, 0,0,0,1,0,0, 0, 0,0));
        tbl.push_back(mk(16, 1,1,1,0,1, 1,0,0,1,0,0, 0, 0,1));
        tbl.push_back(mk(16, 1,1,1,0,1, 1,1,1,0,1,0, 0, 0,1));
        tbl.push_back(mk(16, 1,1,1,0,1, 1,0,1,1,0,1, 0, 1,1));
        tbl.push_back(mk(16, 1,1,1,0,1, 1,1,1,0,1,0, 0, 0,1));
        tbl.push_back(mk(1,  1,1,1,1,1, 1,0,1,1,0,1, 0, 0,1));
        tbl.push_back(mk(15, 1,1,1,0,1, 1,0,1,1,0,1, 1, 1,1));
        tbl.push_back(mk(16, 1,1,1,0,1, 1,1,1,0,1,0, 0, 0,1));
        tbl.push_back(mk(1,  1,1,0,1,1, 1,0,0,1,0,0, 0, 0,1));
        tbl.push_back(mk(16, 1,1,0,0,1, 0,0,1,1,0,1, 0, 1,0));
        tbl.push_back(mk(1,  1,1,0,1,1, 1,0,0,1,0,0, 0, 0,0));
        tbl.push_back(mk(16, 1,1,1,0,1, 1,0,0,1,0,0, 0, 0,1));
        tbl.push_back(mk(7,  1,1,1,0,1, 1,1,1,0,1,0, 0, 0,1));
        tbl.push_back(mk(2,  1,1,0,0,1, 1,0,0,0,1,0, 0, 0,1));
        tbl.push_back(mk(3,  1,0,1,0,1, 0,0,0,0,1,0, 0, 0,1));
        tbl.push_back(mk(9,  1,1,1,0,1, 1,1,1,0,1,0, 0, 0,1));
        tbl.push_back(mk(16, 1,1,1,0,1, 1,0,1,1,0,1, 0, 1,1));
        tbl.push_back(mk(5,  1,1,1,0,1, 1,1,1,0,1,0, 0, 0,1));
        tbl.push_back(mk(1,  0,1,1,0,1, 1,1,1,0,1,0, 0, 0,0));
        tbl.push_back(mk(1,  1,1,0,0,1, 1,0,0,1,0,0, 0, 0,0));
        tbl.push_back(mk(16, 1,1,1,0,1, 1,0,0,1,0,0, 0, 0,1));

        foreach (tbl[k]) run_vec(tbl[k]);

        // Drain interrupted by en=0: index must resume where it stopped
        run_vec(mk(16, 1,1,1,0,1, 1,1,1,0,1,0, 0, 0,1));
        run_vec(mk(1,  1,1,0,1,1, 1,0,0,1,0,0, 0, 0,1));
        run_vec(mk(4,  1,1,0,0,1, 0,0,1,1,0,1, 0, 0,1));
        run_vec(mk(2,  1,0,0,0,1, 0,0,0,1,0,0, 0, 0,1));
        run_vec(mk(12, 1,1,0,0,1, 0,0,1,1,0,1, 4, 1,0));

        // Flush in FILL with pending but cnt!=0 is ignored
        run_vec(mk(16, 1,1,1,0,1, 1,0,0,1,0,0, 0, 0,1));
        run_vec(mk(16, 1,1,1,0,1, 1,1,1,0,1,0, 0, 0,1));
        run_vec(mk(3,  1,1,1,0,1, 1,0,1,1,0,1, 0, 0,1));
        run_vec(mk(1,  1,1,0,1,1, 1,0,0,1,0,0, 0, 0,1));
        run_vec(mk(13, 1,1,1,0,1, 1,0,1,1,0,1, 3, 1,1));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
